// File: rtl/tstamp_capture_array.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tstamp_capture_array
//
// Multi-channel time-to-digital capture block. A free-running counter is
// sampled whenever a channel's asynchronous stop signal rises. Each capture
// waits in a one-deep per-channel pending register. A fixed-priority arbiter
// moves pending entries into a first-word fall-through event FIFO.
//
// Parameters
//   CNT_W  timestamp counter width (16..64)
//   NCH    number of stop channels (1..16)
//   DEPTH  event FIFO depth, power of two (2..64)
//
// Ports
//   tstamp_clk    sole clock, rising edge
//   tstamp_rst_n  asynchronous active-low reset
//   cnt_clr       synchronous counter clear (overrides increment)
//   stop_in       asynchronous per-channel stop inputs
//   ch_en         per-channel capture enable
//   rd_ready      consumer accepts the head entry this cycle
//   ovf_clr       clears ovf_sticky and drop_cnt
//   rd_data       head entry {channel index, timestamp}
//   rd_valid      FIFO holds at least one entry
//   fifo_level    number of entries stored
//   tstamp_now    live counter value
//   cnt_wrap      one-cycle pulse when the counter rolls over to zero
//   ovf_sticky    at least one event dropped since the last clear
//   drop_cnt      dropped-event count, saturating at 255
// -----------------------------------------------------------------------------
module tstamp_capture_array #(
  parameter  int CNT_W = 48,
  parameter  int NCH   = 4,
  parameter  int DEPTH = 8,
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int LV_W  = $clog2(DEPTH) + 1
) (
  input  logic                  tstamp_clk,
  input  logic                  tstamp_rst_n,
  input  logic                  cnt_clr,
  input  logic [NCH-1:0]        stop_in,
  input  logic [NCH-1:0]        ch_en,
  input  logic                  rd_ready,
  input  logic                  ovf_clr,
  output logic [CH_W+CNT_W-1:0] rd_data,
  output logic                  rd_valid,
  output logic [LV_W-1:0]       fifo_level,
  output logic [CNT_W-1:0]      tstamp_now,
  output logic                  cnt_wrap,
  output logic                  ovf_sticky,
  output logic [7:0]            drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = CH_W + CNT_W;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Number of set bits in a per-channel vector (NCH <= 16 fits in 5 bits).
  function automatic logic [4:0] popcnt(input logic [NCH-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < NCH; i++) begin
      n = n + 5'(v[i]);
    end
    return n;
  endfunction

  // 8-bit add that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [4:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {4'b0000, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Timestamp counter
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_p0;

  always_ff @(posedge tstamp_clk or negedge tstamp_rst_n) begin
    if (!tstamp_rst_n) begin
      cnt_p0   <= '0;
      cnt_wrap <= 1'b0;
    end else begin
      // A clear landing on all-ones is a load, not a rollover.
      cnt_wrap <= ~cnt_clr & (&cnt_p0);
      cnt_p0   <= cnt_clr ? '0 : cnt_p0 + CNT_W'(1);
    end
  end

  assign tstamp_now = cnt_p0;

  // ---------------------------------------------------------------------------
  // Stage p0/p1: two-flop synchroniser; p2: previous synced value for edges
  // ---------------------------------------------------------------------------
  logic [NCH-1:0] stop_meta_p0;
  logic [NCH-1:0] stop_sync_p1;
  logic [NCH-1:0] stop_prev_p2;
  logic [NCH-1:0] rise;

  always_ff @(posedge tstamp_clk or negedge tstamp_rst_n) begin
    if (!tstamp_rst_n) begin
      stop_meta_p0 <= '0;
      stop_sync_p1 <= '0;
      stop_prev_p2 <= '0;
    end else begin
      stop_meta_p0 <= stop_in;
      stop_sync_p1 <= stop_meta_p0;
      stop_prev_p2 <= stop_sync_p1;
    end
  end

  // Edge detectors reset to 0, so a stop held high through reset release
  // still yields exactly one rise per channel.
  assign rise = stop_sync_p1 & ~stop_prev_p2;

  // ---------------------------------------------------------------------------
  // Pending registers and fixed-priority arbiter
  // ---------------------------------------------------------------------------
  logic [NCH-1:0]   pend_vld_p0;
  logic [CNT_W-1:0] pend_ts_p0 [NCH];
  logic             push_any;
  logic [CH_W-1:0]  push_ch;
  logic             fifo_full;
  logic             push;
  logic             pop;
  logic [NCH-1:0]   push_oh;
  logic [NCH-1:0]   pend_hold;
  logic [NCH-1:0]   cap;
  logic [NCH-1:0]   drop;
  logic [4:0]       n_drop;

  // Scan from the top so the lowest pending index is the last one written.
  always_comb begin
    push_any = 1'b0;
    push_ch  = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pend_vld_p0[i]) begin
        push_any = 1'b1;
        push_ch  = CH_W'(i);
      end
    end
  end

  assign fifo_full = (fifo_level == LV_W'(DEPTH));
  // A pop never frees room for a push in the same cycle when full.
  assign push      = push_any & ~fifo_full;
  assign pop       = rd_valid & rd_ready;
  assign push_oh   = push ? (NCH'(1) << push_ch) : '0;

  // Occupancy after this cycle's push; a channel draining now may accept
  // a fresh rise instead of dropping it.
  assign pend_hold = pend_vld_p0 & ~push_oh;
  assign cap       = rise & ch_en & ~pend_hold;
  assign drop      = rise & ch_en &  pend_hold;
  assign n_drop    = popcnt(drop);

  always_ff @(posedge tstamp_clk or negedge tstamp_rst_n) begin
    if (!tstamp_rst_n) begin
      pend_vld_p0 <= '0;
    end else begin
      pend_vld_p0 <= pend_hold | cap;
    end
  end

  always_ff @(posedge tstamp_clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (cap[i]) begin
        pend_ts_p0[i] <= cnt_p0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Overflow accounting
  // ---------------------------------------------------------------------------
  always_ff @(posedge tstamp_clk or negedge tstamp_rst_n) begin
    if (!tstamp_rst_n) begin
      ovf_sticky <= 1'b0;
      drop_cnt   <= '0;
    end else if (ovf_clr) begin
      // Drops in the clearing cycle survive the clear.
      ovf_sticky <= (n_drop != '0);
      drop_cnt   <= sat_add8(8'h00, n_drop);
    end else begin
      ovf_sticky <= ovf_sticky | (n_drop != '0);
      drop_cnt   <= sat_add8(drop_cnt, n_drop);
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO, first-word fall-through
  // ---------------------------------------------------------------------------
  logic [ENT_W-1:0] fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge tstamp_clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {push_ch, pend_ts_p0[push_ch]};
    end
  end

  always_ff @(posedge tstamp_clk or negedge tstamp_rst_n) begin
    if (!tstamp_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LV_W'(1);
        2'b01:   fifo_level <= fifo_level - LV_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  assign rd_valid = (fifo_level != '0);
  assign rd_data  = fifo_mem[rd_ptr];

endmodule

// File: doc/tstamp_capture_array.md
TSTAMP_CAPTURE_ARRAY -- requirements
Module: tstamp_capture_array

Interface
REQ-001 Parameter CNT_W, default 48, timestamp counter width (16..64).
REQ-002 Parameter NCH, default 4, number of stop channels (1..16); CH_W = max(1, clog2(NCH)).
REQ-003 Parameter DEPTH, default 8, event FIFO depth (power of 2, 2..64); LV_W = clog2(DEPTH)+1.
REQ-004 tstamp_clk  in  1  sole clock; all state updates on rising edge.
REQ-005 tstamp_rst_n  in  1  asynchronous active-low reset.
REQ-006 cnt_clr  in  1  synchronous counter clear.
REQ-007 stop_in  in  NCH  asynchronous per-channel stop signals.
REQ-008 ch_en  in  NCH  per-channel capture enable.
REQ-009 rd_ready  in  1  consumer accepts head entry.
REQ-010 ovf_clr  in  1  clears ovf_sticky and drop_cnt.
REQ-011 rd_data  out  CH_W+CNT_W  head entry {channel index, timestamp}.
REQ-012 rd_valid  out  1  FIFO non-empty.
REQ-013 fifo_level  out  LV_W  entries currently stored.
REQ-014 tstamp_now  out  CNT_W  live counter value.
REQ-015 cnt_wrap  out  1  one-cycle pulse on counter wrap.
REQ-016 ovf_sticky  out  1  at least one event dropped since last clear.
REQ-017 drop_cnt  out  8  dropped-event count, saturating at 255.

Function
REQ-018 Counter: +1 per cycle, modulo 2^CNT_W; cnt_clr loads 0 on the next edge, overriding increment.
REQ-019 On the all-ones to 0 increment, cnt_wrap is high for exactly one cycle; cnt_clr never pulses cnt_wrap.
REQ-020 Each stop_in bit: 2-flop synchroniser, then a third flop; rise = sync & ~prev.
REQ-021 A rise with ch_en=1 captures the current tstamp_now into that channel's pending register and sets its pending flag on the next edge.
REQ-022 A rise with ch_en=0 is ignored without drop accounting; an already-pending entry on a disabled channel still drains.
REQ-023 A rise on a channel whose pending flag is set, and not cleared that same cycle, is dropped: ovf_sticky is set and drop_cnt increments (saturating).
REQ-024 Arbiter: fixed priority, lowest channel index wins; at most one pending entry pushes per cycle, only when fifo_level < DEPTH.
REQ-025 A pushed channel's pending flag clears on the push edge; a new rise on that channel in the same cycle is accepted, not dropped.
REQ-026 Simultaneous rises on several channels capture the same timestamp and enter the FIFO on consecutive cycles in index order.
REQ-027 FIFO is first-word fall-through: rd_valid = (fifo_level != 0); rd_data is the oldest entry.
REQ-028 Pop occurs when rd_valid & rd_ready.
REQ-029 Push and pop in the same cycle leave fifo_level unchanged.
REQ-030 When full, no push occurs even if a pop happens that cycle; entries wait in their pending registers.
REQ-031 Latency: a stop_in rise sampled at edge k captures the counter value present after edge k+1; rd_valid is set after edge k+3 when the FIFO is empty and there is no contention.
REQ-032 ovf_clr zeroes ovf_sticky and drop_cnt on the next edge; a drop in the same cycle wins (sticky=1, drop_cnt=1).
REQ-033 cnt_clr does not affect pending registers, FIFO, or overflow state.

Reset
REQ-034 While tstamp_rst_n=0: counter, synchroniser flops, pending flags, FIFO pointers, fifo_level, ovf_sticky, drop_cnt, and cnt_wrap are all 0; rd_valid=0.
REQ-035 Reset asserted mid-operation discards all pending and queued events immediately.
REQ-036 After reset release, a stop_in already held high produces one capture per enabled channel, because the edge-detect flops reset to 0.

Verification
REQ-037 Single event: stop_in[2] rises, sampled at the edge where the counter becomes 100 -> rd_data={2,101}, rd_valid high after 3 edges, fifo_level=1.
REQ-038 Simultaneous: stop_in[3:0] rise together, rd_ready=0 -> 4 entries with equal timestamps in order ch0, ch1, ch2, ch3; fifo_level=4.
REQ-039 Overflow: DEPTH=8, rd_ready=0, 10 single-channel events on ch0 and ch1 -> fifo_level=8, 2 events held pending; a further ch0 rise -> ovf_sticky=1, drop_cnt=1; after 2 pops, the pending entries enter the FIFO.
REQ-040 Wrap: CNT_W=16, counter running from reset -> cnt_wrap pulses once at count 65535->0; cnt_clr at count 500 -> 0, no pulse.
REQ-041 Disabled channel: ch_en[1]=0 and stop_in[1] rises -> no entry, drop_cnt unchanged; ch_en[1]=1 on a later rise -> entry captured.
REQ-042 Async reset: tstamp_rst_n pulsed low for half a cycle with 3 entries queued -> rd_valid=0, fifo_level=0, tstamp_now=0 immediately.
